pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised pipeline stall/flush controller for an N-stage in-order core. It takes per-stage stall and flush requests and produces registered per-stage stall, bubble and flush enables. Unlike a single global stall/flush flag, it applies stage-accurate masks, lets an older flush override a younger stall, and holds flushes for several cycles. It also reports stall statistics and a sticky stall-timeout flag. It sits between the stage blocks (fetch … writeback) and their pipeline registers.

## Interface
- NUM_STAGES, 5, number of stages; index 0 = youngest (fetch), NUM_STAGES-1 = oldest (writeback); ≥2
- FLUSH_HOLD, 2, cycles a flush mask stays asserted after acceptance; ≥1
- STALL_TIMEOUT, 64, consecutive stalled cycles before stall_timeout sets; ≥1
- CNT_W, 16, width of stall_cycles
- s_clk  input  1  clock, rising edge
- s_rst  input  1  reset, asynchronous, active-low
- stall_req  input  NUM_STAGES  per-stage stall request, level
- flush_req  input  NUM_STAGES  per-stage flush request (stage i kills all younger stages), level
- timeout_clr  input  1  clears stall_timeout and the timeout counter
- stall_out  output  NUM_STAGES  hold pipeline register of stage j
- bubble_out  output  NUM_STAGES  load NOP into stage j
- flush_out  output  NUM_STAGES  kill contents of stage j
- flush_ack  output  1  one-cycle pulse: a flush request was accepted
- stall_timeout  output  1  sticky: stall persisted STALL_TIMEOUT cycles
- stall_cycles  output  CNT_W  saturating count of cycles with stall_out ≠ 0

## Operation
- Per cycle, compute s = highest index with stall_req set and f = highest index with flush_req set. Either may be "none".
- Flush acceptance:
  - A flush is accepted iff f exists and (s is none or f > s).
  - If f ≤ s, the stall wins and the flush is ignored. The requester must hold flush_req.
- Accepted flush:
  - new mask M = bits [f-1:0] set; f=0 gives an empty mask but still acks.
  - flush_ack pulses.
  - Hold counter loads FLUSH_HOLD-1.
  - Mask register loads M OR current held mask if the hold counter is nonzero, otherwise M.
- Hold:
  - While the hold counter is >0 and no new accept, flush_out keeps the held mask and the counter decrements.
  - At 0 with no accept, the mask clears.
- Stall, when s exists:
  - stall_out bits [s:0] are set.
  - bubble_out bit s+1 is set if s < NUM_STAGES-1.
  - When a flush is accepted this cycle, stall_out and bubble_out are 0.
- Per-stage priority: the final stall_out and bubble_out are ANDed with ~flush_out (next value). A flushed stage is never stalled or bubbled.
- stall_req bits of stages inside the currently held flush mask are ignored when computing s.
- Timeout:
  - A counter increments on each edge where the registered stall_out ≠ 0. It resets to 0 on an edge where stall_out = 0.
  - When it reaches STALL_TIMEOUT, stall_timeout sets and stays set.
  - timeout_clr zeroes the counter and the flag; clear wins over set in the same cycle.
- stall_cycles increments on each edge with registered stall_out ≠ 0 and saturates at all-ones.

## Timing
- Every output is registered. A request sampled at edge t is visible after edge t, for exactly one cycle if the request drops.
- flush_out stays asserted for exactly FLUSH_HOLD cycles after acceptance, unless extended by a new accept.
- Reset (s_rst low) asynchronously forces all outputs, counters, the mask and the flag to 0. Reset in the middle of a hold aborts the hold immediately.
- stall_timeout becomes visible the cycle after the STALL_TIMEOUT-th consecutive cycle with stall_out ≠ 0.

## Test plan
All cases use NUM_STAGES=5, FLUSH_HOLD=2, STALL_TIMEOUT=4.
- Reset: drive reqs during reset → all outputs 0. Assert s_rst low mid-hold → flush_out = 0 immediately, without waiting for a clock edge.
- stall_req=00100 for 1 cycle → next cycle stall_out=00111 and bubble_out=01000; the cycle after, both are 0. stall_cycles=1.
- flush_req=00100 for 1 cycle, no stall → flush_out=00011 for exactly 2 cycles, flush_ack high for the first only, stall_out=0.
- Priority, stall wins: stall_req=01000 with flush_req=00100 → stall_out=01111, bubble_out=10000, flush_out=0, flush_ack=0.
- Priority, flush wins: stall_req=00010 with flush_req=01000 → flush_out=00111, stall_out=0, flush_ack=1.
- Hold extension: flush_req=00100 at cycle 0, then flush_req=01000 at cycle 1 → flush_out=00011 in cycle 1, then 00111 in cycles 2–3, then 0.
- Timeout: stall_req=00001 held 6 cycles → stall_timeout rises in the 5th output cycle and stays high; stall_cycles=6. Pulse timeout_clr → flag 0. A 3-cycle stall afterwards does not set the flag.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stage-accurate pipeline stall/bubble/flush controller
// An older accepted flush overrides younger stalls; flush masks are held and merged across accepts.
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES    = 5,
    parameter int FLUSH_HOLD    = 2,
    parameter int STALL_TIMEOUT = 64,
    parameter int CNT_W         = 16
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic [NUM_STAGES-1:0] flush_req,
    input  logic                  timeout_clr,
    output logic [NUM_STAGES-1:0] stall_out,
    output logic [NUM_STAGES-1:0] bubble_out,
    output logic [NUM_STAGES-1:0] flush_out,
    output logic                  flush_ack,
    output logic                  stall_timeout,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam int TO_W   = $clog2(STALL_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_HOLD - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(STALL_TIMEOUT);
    localparam logic [TO_W-1:0]   TO_SET    = TO_W'(STALL_TIMEOUT - 1);

    logic [HOLD_W-1:0]     hold_cnt;
    logic [HOLD_W-1:0]     hold_cnt_n;
    logic [TO_W-1:0]       to_cnt;
    logic [NUM_STAGES-1:0] eff_stall;
    logic [NUM_STAGES-1:0] new_mask;
    logic [NUM_STAGES-1:0] flush_n;
    logic [NUM_STAGES-1:0] stall_n;
    logic [NUM_STAGES-1:0] bubble_n;
    logic                  s_vld;
    logic                  f_vld;
    logic                  accept;
    int                    s_idx;
    int                    f_idx;

    // Stages already being flushed cannot hold the pipeline.
    always_comb begin
        eff_stall = stall_req & ~flush_out;
        s_vld     = 1'b0;
        s_idx     = 0;
        f_vld     = 1'b0;
        f_idx     = 0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (eff_stall[i]) begin
                s_vld = 1'b1;
                s_idx = i;
            end
            if (flush_req[i]) begin
                f_vld = 1'b1;
                f_idx = i;
            end
        end
    end

    assign accept = f_vld && (!s_vld || (f_idx > s_idx));

    always_comb begin
        new_mask = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            new_mask[j] = (j < f_idx);
        end
    end

    always_comb begin
        flush_n    = '0;
        hold_cnt_n = '0;
        if (accept) begin
            flush_n    = new_mask | ((hold_cnt != '0) ? flush_out : '0);
            hold_cnt_n = HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            flush_n    = flush_out;
            hold_cnt_n = hold_cnt - 1'b1;
        end
    end

    always_comb begin
        stall_n  = '0;
        bubble_n = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            stall_n[j]  = s_vld && !accept && (j <= s_idx) && !flush_n[j];
            bubble_n[j] = s_vld && !accept && (j == s_idx + 1) && !flush_n[j];
        end
    end

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            stall_out  <= '0;
            bubble_out <= '0;
            flush_out  <= '0;
            flush_ack  <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            stall_out  <= stall_n;
            bubble_out <= bubble_n;
            flush_out  <= flush_n;
            flush_ack  <= accept;
            hold_cnt   <= hold_cnt_n;
        end
    end

    // The timeout counter saturates so a long stall cannot wrap and re-arm it.
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            to_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else if (timeout_clr) begin
            to_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else if (stall_out != '0) begin
            if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_cnt >= TO_SET) begin
                stall_timeout <= 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            stall_cycles <= '0;
        end else if ((stall_out != '0) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and random checks of pipeline_hazard_ctrl
// Reference model tracks flush visibility as remaining cycles and stalls as run lengths.
module tb_pipeline_hazard_ctrl;

    localparam int N    = 5;
    localparam int HOLD = 2;
    localparam int TO   = 4;
    localparam int CW   = 16;

    logic          s_clk = 1'b0;
    logic          s_rst = 1'b0;
    logic [N-1:0]  stall_req = '0;
    logic [N-1:0]  flush_req = '0;
    logic          timeout_clr = 1'b0;
    logic [N-1:0]  stall_out;
    logic [N-1:0]  bubble_out;
    logic [N-1:0]  flush_out;
    logic          flush_ack;
    logic          stall_timeout;
    logic [CW-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] m_stall, m_bubble, m_flush;
    logic         m_ack, m_to;
    int           m_cyc, m_rem, m_run;

    pipeline_hazard_ctrl #(
        .NUM_STAGES(N), .FLUSH_HOLD(HOLD), .STALL_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst), .stall_req(stall_req), .flush_req(flush_req),
        .timeout_clr(timeout_clr), .stall_out(stall_out), .bubble_out(bubble_out),
        .flush_out(flush_out), .flush_ack(flush_ack), .stall_timeout(stall_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 s_clk = ~s_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stall = '0; m_bubble = '0; m_flush = '0; m_ack = 1'b0; m_to = 1'b0;
        m_cyc = 0; m_rem = 0; m_run = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".stall"},  32'(stall_out),     32'(m_stall));
        check({tag, ".bubble"}, 32'(bubble_out),    32'(m_bubble));
        check({tag, ".flush"},  32'(flush_out),     32'(m_flush));
        check({tag, ".ack"},    32'(flush_ack),     32'(m_ack));
        check({tag, ".tmo"},    32'(stall_timeout), 32'(m_to));
        check({tag, ".cyc"},    32'(stall_cycles),  32'(m_cyc));
    endtask

    task automatic step(input logic [N-1:0] sr, input logic [N-1:0] fr, input logic clr, input string tag);
        logic [N-1:0] eff, nm, ns, nb;
        int s, f, nrem;
        logic acc;
        @(negedge s_clk);
        stall_req = sr; flush_req = fr; timeout_clr = clr;
        eff = sr & ~m_flush;
        s = -1; f = -1;
        for (int i = 0; i < N; i++) begin
            if (eff[i]) s = i;
            if (fr[i])  f = i;
        end
        acc = (f >= 0) && (f > s);
        if (acc) begin
            nm   = N'((1 << f) - 1) | ((m_rem > 1) ? m_flush : '0);
            nrem = HOLD;
        end else if (m_rem > 0) begin
            nrem = m_rem - 1;
            nm   = (nrem > 0) ? m_flush : '0;
        end else begin
            nrem = 0;
            nm   = '0;
        end
        ns = (s >= 0 && !acc) ? N'((1 << (s + 1)) - 1) : '0;
        nb = (s >= 0 && !acc && s < N - 1) ? N'(1 << (s + 1)) : '0;
        ns = ns & ~nm;
        nb = nb & ~nm;
        @(posedge s_clk);
        #1;
        if (clr) begin
            m_run = 0; m_to = 1'b0;
        end else if (m_stall != '0) begin
            m_run++;
            if (m_run >= TO) m_to = 1'b1;
        end else begin
            m_run = 0;
        end
        if (m_stall != '0 && m_cyc < 65535) m_cyc++;
        m_stall = ns; m_bubble = nb; m_flush = nm; m_ack = acc; m_rem = nrem;
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #3;
        s_rst = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge s_clk);
        stall_req = '0; flush_req = '0; timeout_clr = 1'b0;
        s_rst = 1'b1;
    endtask

    initial begin
        model_reset();
        stall_req = 5'b11111; flush_req = 5'b10101;
        repeat (3) @(posedge s_clk);
        #1;
        compare_all("reset");
        check("reset.flush_const", 32'(flush_out), 32'h0);
        @(negedge s_clk);
        stall_req = '0; flush_req = '0;
        s_rst = 1'b1;

        step(5'b00100, 5'b00000, 1'b0, "stall1");
        check("stall1.stall_const", 32'(stall_out), 32'h07);
        check("stall1.bubble_const", 32'(bubble_out), 32'h08);
        step(5'b00000, 5'b00000, 1'b0, "stall1_end");
        check("stall1.cyc_const", 32'(stall_cycles), 32'd1);

        step(5'b00000, 5'b00100, 1'b0, "flush1");
        check("flush1.flush_const", 32'(flush_out), 32'h03);
        check("flush1.ack_const", 32'(flush_ack), 32'h1);
        step(5'b00000, 5'b00000, 1'b0, "flush1_hold");
        check("flush1_hold.flush_const", 32'(flush_out), 32'h03);
        check("flush1_hold.ack_const", 32'(flush_ack), 32'h0);
        step(5'b00000, 5'b00000, 1'b0, "flush1_end");
        check("flush1_end.flush_const", 32'(flush_out), 32'h0);

        step(5'b01000, 5'b00100, 1'b0, "stall_wins");
        check("stall_wins.stall_const", 32'(stall_out), 32'h0f);
        check("stall_wins.bubble_const", 32'(bubble_out), 32'h10);
        step(5'b00010, 5'b01000, 1'b0, "flush_wins");
        check("flush_wins.flush_const", 32'(flush_out), 32'h07);
        check("flush_wins.stall_const", 32'(stall_out), 32'h0);
        step(5'b00000, 5'b00000, 1'b0, "drain_a");
        step(5'b00000, 5'b00000, 1'b0, "drain_b");

        step(5'b00000, 5'b00100, 1'b0, "ext_c1");
        check("ext_c1.flush_const", 32'(flush_out), 32'h03);
        step(5'b00000, 5'b01000, 1'b0, "ext_c2");
        check("ext_c2.flush_const", 32'(flush_out), 32'h07);
        step(5'b00000, 5'b00000, 1'b0, "ext_c3");
        check("ext_c3.flush_const", 32'(flush_out), 32'h07);
        step(5'b00000, 5'b00000, 1'b0, "ext_c4");
        check("ext_c4.flush_const", 32'(flush_out), 32'h0);

        step(5'b00000, 5'b00010, 1'b0, "midhold");
        async_reset("midhold_rst");

        for (int k = 1; k <= 6; k++) begin
            step(5'b00001, 5'b00000, 1'b0, "tmo_run");
            if (k == 4) check("tmo.before", 32'(stall_timeout), 32'h0);
            if (k == 5) check("tmo.rise", 32'(stall_timeout), 32'h1);
        end
        step(5'b00000, 5'b00000, 1'b0, "tmo_end");
        check("tmo.cyc_const", 32'(stall_cycles), 32'd6);
        check("tmo.sticky", 32'(stall_timeout), 32'h1);
        step(5'b00000, 5'b00000, 1'b1, "tmo_clr");
        check("tmo.cleared", 32'(stall_timeout), 32'h0);
        repeat (3) step(5'b00001, 5'b00000, 1'b0, "tmo_short");
        repeat (2) step(5'b00000, 5'b00000, 1'b0, "tmo_short_end");
        check("tmo.short_noset", 32'(stall_timeout), 32'h0);

        for (int r = 0; r < 400; r++) begin
            logic [N-1:0] sr, fr;
            logic clr;
            sr  = N'($urandom) & N'($urandom);
            fr  = ($urandom_range(0, 2) == 0) ? (N'($urandom) & N'($urandom)) : '0;
            clr = ($urandom_range(0, 15) == 0);
            step(sr, fr, clr, "rand");
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
